// File: rtl/nibble_serial_alu.sv
// nibble_serial_alu: add/subtract one 4-bit carry-lookahead slice per cycle, NIBBLES cycles per operation
module nibble_serial_alu #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 op,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 ovf,
    output logic                 zero,
    output logic                 neg
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d, acc_nx;
    logic [IW-1:0]  idx_q, idx_d;
    logic           op_q, op_d, carry_q, carry_d, busy_q, busy_d, done_q, done_d;
    logic           cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;
    logic [3:0]     an, bn, g, p, sum;
    logic [4:0]     c;
    always_comb begin
        an     = 4'(a_q >> {idx_q, 2'b00});
        bn     = 4'(b_q >> {idx_q, 2'b00}) ^ {4{op_q}};
        g      = an & bn;
        p      = an ^ bn;
        c[0]   = carry_q;
        c[1]   = g[0] | (p[0] & c[0]);
        c[2]   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4]   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | ((&p) & c[0]);
        sum    = p ^ c[3:0];
        acc_nx = (acc_q & ~(W'(4'hF) << {idx_q, 2'b00})) | (W'(sum) << {idx_q, 2'b00});
    end
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        acc_d    = acc_q;
        busy_d   = busy_q;
        done_d   = done_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        if (state_q == BUSY) begin
            acc_d   = acc_nx;
            carry_d = c[4];
            if (idx_q == IW'(NIBBLES - 1)) begin
                state_d  = DONE;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                result_d = acc_nx;
                cout_d   = c[4];
                ovf_d    = (a_q[W-1] == (b_q[W-1] ^ op_q)) && (acc_nx[W-1] != a_q[W-1]);
                zero_d   = acc_nx == '0;
                neg_d    = acc_nx[W-1];
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (start) begin
            a_d     = a;
            b_d     = b;
            op_d    = op;
            idx_d   = '0;
            carry_d = op;
            state_d = BUSY;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end else begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;
    assign neg    = neg_q;
endmodule
